// File: rtl/beam_scan_if.sv
// Handshake/bus bundle between the beam-scan controller and the array/CIC datapath.
// master: datapath/stimulus side, slave: controller side.
interface beam_scan_if #(
  parameter int LOG_WIN = 4
);
  logic                   start;
  logic                   sample_valid;
  logic [7:0]             sample;
  logic [4:0]             delay_select;
  logic                   busy;
  logic                   done;
  logic [4:0]             best_delay;
  logic [8+LOG_WIN-1:0]   best_energy;

  modport master (
    output start, sample_valid, sample,
    input  delay_select, busy, done, best_delay, best_energy
  );

  modport slave (
    input  start, sample_valid, sample,
    output delay_select, busy, done, best_delay, best_energy
  );
endinterface

// File: rtl/beam_scan_controller.sv
// Sweeps the beamformer delay-select, measures |sample| energy per position and parks on the loudest.
// Optional continuous re-scan when BEAM_SCAN_TRACK_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start, delay_select holds last winner
// SETTLE  | discarding strobes while the CIC settles after a delay change
// ACCUM   | summing |sample| over 2^LOG_WIN strobes
// COMPARE | one cycle: update best, advance or finish
// DONE    | one cycle: done pulse, delay_select = best_delay
module beam_scan_controller #(
  parameter int NUM_DELAYS = 32,
  parameter int LOG_WIN    = 4,
  parameter int SETTLE     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  beam_scan_if.slave  bus
);
  localparam int         ACC_W   = 8 + LOG_WIN;
  localparam logic [8:0] SET_LEN = 9'(SETTLE);
  localparam logic [8:0] WIN_LEN = 9'(1 << LOG_WIN);
  localparam logic [4:0] LAST    = 5'(NUM_DELAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_ACCUM, S_COMPARE, S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [8:0]         r_cnt, w_cnt;
  logic [ACC_W-1:0]   r_acc, w_acc;
  logic [4:0]         r_delay, w_delay;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic [4:0]         r_best_delay, w_best_delay;
  logic [ACC_W-1:0]   r_best_energy, w_best_energy;

  logic [7:0]         w_mag;
  logic               w_better;

  // -128 negates to 0x80 which reads as 128 unsigned, so 8 bits hold every magnitude
  assign w_mag    = bus.sample[7] ? 8'(~bus.sample + 8'd1) : bus.sample;
  assign w_better = (r_acc > r_best_energy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_delay       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_best_delay  <= '0;
      r_best_energy <= '0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_acc         <= w_acc;
      r_delay       <= w_delay;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_best_delay  <= w_best_delay;
      r_best_energy <= w_best_energy;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_acc         = r_acc;
    w_delay       = r_delay;
    w_busy        = r_busy;
    w_done        = 1'b0;
    w_best_delay  = r_best_delay;
    w_best_energy = r_best_energy;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state       = S_SETTLE;
          w_delay       = '0;
          w_best_delay  = '0;
          w_best_energy = '0;
          w_busy        = 1'b1;
          w_cnt         = SET_LEN;
        end
      end

      S_SETTLE: begin
        // a zero count here means SETTLE=0: leave on the next cycle without a strobe
        if (r_cnt == 9'd0 || (bus.sample_valid && r_cnt == 9'd1)) begin
          w_state = S_ACCUM;
          w_cnt   = WIN_LEN;
          w_acc   = '0;
        end else if (bus.sample_valid) begin
          w_cnt = r_cnt - 9'd1;
        end
      end

      S_ACCUM: begin
        if (bus.sample_valid) begin
          w_acc = r_acc + {{LOG_WIN{1'b0}}, w_mag};
          if (r_cnt == 9'd1) begin
            w_state = S_COMPARE;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt - 9'd1;
          end
        end
      end

      S_COMPARE: begin
        if (w_better) begin
          w_best_energy = r_acc;
          w_best_delay  = r_delay;
        end
        if (r_delay == LAST) begin
          w_state = S_DONE;
          w_done  = 1'b1;
          w_delay = w_better ? r_delay : r_best_delay;
        end else begin
          w_state = S_SETTLE;
          w_delay = r_delay + 5'd1;
          w_cnt   = SET_LEN;
        end
      end

      S_DONE: begin
`ifdef BEAM_SCAN_TRACK_EN
        w_state       = S_SETTLE;
        w_delay       = '0;
        w_best_delay  = '0;
        w_best_energy = '0;
        w_cnt         = SET_LEN;
`else
        w_state = S_IDLE;
        w_busy  = 1'b0;
`endif
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign bus.delay_select = r_delay;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.best_delay   = r_best_delay;
  assign bus.best_energy  = r_best_energy;

endmodule

// File: tb/tb_beam_scan_controller.sv
// Directed self-checking bench for beam_scan_controller (NUM_DELAYS=8, LOG_WIN=2, SETTLE=2).
module tb_beam_scan_controller;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   done_cnt;
  logic [4:0]  cap_delay;
  logic [9:0]  cap_energy;

  beam_scan_if #(.LOG_WIN(2)) bus ();

  beam_scan_controller #(
    .NUM_DELAYS(8),
    .LOG_WIN   (2),
    .SETTLE    (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt   = done_cnt + 1;
      cap_delay  = bus.best_delay;
      cap_energy = bus.best_energy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp)
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] val);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample       = val;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.sample       = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] pattern(input int pat, input int p, input int k);
    case (pat)
      1:       return (p == 5) ? 8'd100 : 8'd10;
      2:       return (p == 2 || p == 6) ? 8'h80 : 8'h00;
      4:       return (p == 3 && k < 2) ? 8'd127 : ((p == 1) ? 8'd5 : 8'd0);
      5:       return (p == 7) ? 8'h9C : 8'd10;
      default: return 8'h00;
    endcase
  endfunction

  task automatic run_scan(input int pat, input logic retrig,
                          input logic [4:0] exp_d, input logic [9:0] exp_e);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("busy_up_p%0d", pat), 32'(bus.busy), 32'd1);
    for (int p = 0; p < 8; p++) begin
      check($sformatf("delay_sel_p%0d_d%0d", pat, p), 32'(bus.delay_select), 32'(p));
      if (retrig && p == 4) begin
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      for (int k = 0; k < 6; k++) strobe(pattern(pat, p, k));
    end
    repeat (10) @(negedge clk);
    check($sformatf("done_count_p%0d", pat), 32'(done_cnt - d0), 32'd1);
    check($sformatf("best_delay_p%0d", pat), 32'(cap_delay), 32'(exp_d));
    check($sformatf("best_energy_p%0d", pat), 32'(cap_energy), 32'(exp_e));
`ifndef BEAM_SCAN_TRACK_EN
    check($sformatf("parked_delay_p%0d", pat), 32'(bus.delay_select), 32'(exp_d));
    check($sformatf("busy_low_p%0d", pat), 32'(bus.busy), 32'd0);
`else
    check($sformatf("busy_held_p%0d", pat), 32'(bus.busy), 32'd1);
`endif
  endtask

  initial begin
    tests            = 0;
    fails            = 0;
    done_cnt         = 0;
    cap_delay        = '0;
    cap_energy       = '0;
    bus.start        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample       = 8'h00;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_delay", 32'(bus.delay_select), 32'd0);
    rst_n = 1'b1;

    // partial scan: two full positions at 10 then abort inside position 2's window
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) strobe(8'd10);
    check("pre_rst_energy", 32'(bus.best_energy), 32'd40);
    check("pre_rst_delay_sel", 32'(bus.delay_select), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_delay_sel", 32'(bus.delay_select), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_best_delay", 32'(bus.best_delay), 32'd0);
    check("arst_best_energy", 32'(bus.best_energy), 32'd0);
    repeat (5) @(negedge clk);
    check("arst_no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;

    run_scan(1, 1'b0, 5'd5, 10'd400);
    run_scan(2, 1'b0, 5'd2, 10'd512);
    run_scan(3, 1'b0, 5'd0, 10'd0);
    run_scan(4, 1'b0, 5'd1, 10'd20);
    run_scan(5, 1'b1, 5'd7, 10'd400);

`ifdef BEAM_SCAN_TRACK_EN
    begin
      int d1;
      d1 = done_cnt;
      for (int i = 0; i < 48; i++) strobe(8'd10);
      repeat (10) @(negedge clk);
      check("track_second_done", 32'(done_cnt - d1), 32'd1);
      check("track_busy", 32'(bus.busy), 32'd1);
      check("track_energy", 32'(cap_energy), 32'd40);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/beam_scan_controller.md
# beam_scan_controller

Steering-scan controller for the PDM microphone-array DDC. It sweeps the 5-bit delay-select word of the beamforming datapath across all steering positions and discards CIC output samples while the filter settles after each change. It then accumulates absolute-value energy over a fixed window and latches the loudest position, leaving the datapath steered there. It sits beside the array/CIC datapath, driving its delay-select input and observing its 8-bit CIC output.

## Interface
- NUM_DELAYS, 32, number of steering positions scanned (2..32), positions 0..NUM_DELAYS-1
- LOG_WIN, 4, energy window = 2^LOG_WIN samples per position (1..8)
- SETTLE, 8, samples discarded after each delay change (0..255)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level-sampled scan request, honoured only in IDLE
- sample_valid  in  1  one-cycle strobe, new CIC sample present
- sample  in  8  CIC output, signed two's complement
- delay_select  out  5  steering word to datapath
- busy  out  1  high from scan start until DONE is left
- done  out  1  one-cycle pulse when scan completes
- best_delay  out  5  index of winning position
- best_energy  out  8+LOG_WIN  winning window energy

## Operation
- States: IDLE, SETTLE, ACCUM, COMPARE, DONE.
- IDLE: busy=0. On start=1, set delay_select=0, clear best_energy=0, best_delay=0, and go to SETTLE.
- SETTLE: count sample_valid strobes. After SETTLE strobes, go to ACCUM with acc=0. If SETTLE=0, go straight to ACCUM on the next cycle.
- ACCUM: on each strobe, acc += |sample|, with |-128| = 128 (9-bit-safe magnitude, unsigned, fits 8 bits). After 2^LOG_WIN strobes, go to COMPARE.
- COMPARE (one cycle): if acc > best_energy (strict), latch best_energy=acc and best_delay=delay_select. Ties keep the lower index. Position 0 always wins if every window is zero.
  - If delay_select = NUM_DELAYS-1, go to DONE.
  - Otherwise increment delay_select and go to SETTLE.
- DONE (one cycle): delay_select=best_delay, done=1, then go to IDLE. delay_select holds best_delay in IDLE.
- Accumulator width is 8+LOG_WIN. Saturation is never needed because the maximum is 128·2^LOG_WIN < 2^(8+LOG_WIN).
- sample_valid in COMPARE or DONE is dropped and is not counted toward the next window.
- start asserted while busy is ignored. start held high through DONE re-arms a scan on the first IDLE cycle.

## Timing
- Reset values: delay_select=0, busy=0, done=0, best_delay=0, best_energy=0. All internal counters and acc are 0 and the state is IDLE.
- Reset mid-scan aborts immediately and asynchronously to these values. No done is issued.
- All outputs are registered.
- delay_select changes the cycle after COMPARE (increment) or on entry to DONE (best).
- busy rises the cycle after start is sampled and falls the cycle after done.
- Per-position cost: SETTLE+2^LOG_WIN strobes, plus 2 clk (COMPARE, state entry).
- Scan latency: NUM_DELAYS·(SETTLE+2^LOG_WIN) strobes plus about 2·NUM_DELAYS+2 clk.
- A strobe in the same cycle as the state entry into SETTLE/ACCUM is counted.

## Configuration
- BEAM_SCAN_TRACK_EN defined: DONE returns to SETTLE with delay_select=0 instead of IDLE. This gives continuous re-scanning.
  - best_energy/best_delay are cleared at each restart, while delay_select shows best only for the DONE cycle.
  - busy stays 1, and done pulses once per completed scan. start=0 in IDLE still idles.
- Undefined: one-shot behaviour as above.

## Test plan
- Reset: drive rst_n=0 mid-ACCUM -> all outputs 0, state IDLE, no done pulse. Release, start=1 -> busy=1 next cycle.
- Peak detection: NUM_DELAYS=8, LOG_WIN=2, SETTLE=2, sample=10 except sample=100 at delay 5 -> best_delay=5, best_energy=400, delay_select=5 after done.
- Tie and negative: samples of -128 at delays 2 and 6, 0 elsewhere -> best_delay=2, best_energy=512 (LOG_WIN=2).
- All-zero input -> best_delay=0, best_energy=0, exactly one done pulse after 8·(2+4)=48 strobes.
- Settling discard: large samples only during SETTLE strobes of delay 3 -> delay 3 does not win.
- start retriggered while busy -> ignored, single done. With BEAM_SCAN_TRACK_EN, two consecutive done pulses 48 strobes apart with busy held at 1.
